seg_display_scan: RTL and testbench



---
 rtl/seg_display_pkg.sv | 29 ++
 rtl/seg_display_scan_if.sv | 13 +
 rtl/seg_display_scan_decode.sv | 31 +++
 rtl/seg_display_scan.sv | 139 +++++++++++++
 tb/tb_seg_display_scan.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg_display_pkg.sv
// Shared types, constants and helpers for the multiplexed 7-segment display.
package seg_display_pkg;

    localparam int BCD_W      = 4;
    localparam int SEG_W      = 7;
    localparam int MAX_DIGITS = 8;

    // Segment vector ordered {a,b,c,d,e,f,g}; a is bit 6.
    typedef logic [SEG_W-1:0] seg_t;

    // Lit patterns (1 = segment on) before output polarity is applied.
    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_BLANK = 7'b0000000;

    // Converts a lit pattern into pin levels for the chosen drive polarity.
    function automatic seg_t seg_polarity(seg_t lit, bit active_low);
        return active_low ? ~lit : lit;
    endfunction

endpackage

// File: rtl/seg_display_scan_if.sv
// Valid/ready load channel carrying a packed BCD value into the display.
interface seg_display_scan_if
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    logic [BCD_W*NUM_DIGITS-1:0] digits_in;
    logic                        load_valid;
    logic                        load_ready;

    modport master (output digits_in, output load_valid, input  load_ready);
    modport slave  (input  digits_in, input  load_valid, output load_ready);
endinterface

// File: rtl/seg_display_scan_decode.sv
// BCD to 7-segment lit pattern; codes above 9 and blanked digits stay dark.
module seg7_decode
    import seg_display_pkg::*;
(
    input  logic [BCD_W-1:0] code,
    input  logic             blank,
    output seg_t             lit
);

    // Map the selected digit code to its segment pattern.
    always_comb begin
        // NOTE: lit gets a default before the case so no path leaves it unassigned and no latch is inferred.
        lit = SEG_BLANK;
        if (!blank) begin
            case (code)
                4'd0:    lit = SEG_0;
                4'd1:    lit = SEG_1;
                4'd2:    lit = SEG_2;
                4'd3:    lit = SEG_3;
                4'd4:    lit = SEG_4;
                4'd5:    lit = SEG_5;
                4'd6:    lit = SEG_6;
                4'd7:    lit = SEG_7;
                4'd8:    lit = SEG_8;
                4'd9:    lit = SEG_9;
                default: lit = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg_display_scan.sv
// Time-multiplexed 7-segment scanner with a one-deep pending buffer that is
// swapped into the display only at frame boundaries.
module seg_display_scan
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 20000,
    parameter bit ACTIVE_LOW  = 1'b1,
    parameter bit BLANK_LZ    = 1'b1
)
(
    input  logic                  clk,
    input  logic                  rst,
    seg_display_scan_if.slave     load_if,
    output seg_t                  seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_done
);

    localparam int CNT_W  = $clog2(REFRESH_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DISP_W = BCD_W * NUM_DIGITS;

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam seg_t                  SEG_OFF  = seg_polarity(SEG_BLANK, ACTIVE_LOW);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DISP_W-1:0]     disp_q, disp_d;
    logic [DISP_W-1:0]     pend_q, pend_d;
    logic                  pend_full_q, pend_full_d;
    logic                  ready_q, ready_d;
    seg_t                  seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_done_q, frame_done_d;

    logic                  tick;
    logic                  frame_end;
    logic                  accept;
    logic                  swap;
    logic [BCD_W-1:0]      cur_code;
    logic                  cur_blank;
    logic                  zero_above;
    seg_t                  cur_lit;
    logic [NUM_DIGITS-1:0] an_onehot;

    assign tick      = (cnt_q == CNT_LAST);
    assign frame_end = tick && (idx_q == IDX_LAST);
    assign accept    = load_if.load_valid && ready_q;
    assign swap      = frame_end && pend_full_q;

    // Pick the scanned digit and decide whether it is a leading zero to blank.
    always_comb begin
        cur_code   = '0;
        cur_blank  = 1'b0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (disp_q[i*BCD_W +: BCD_W] == '0);
            if (idx_q == IDX_W'(i)) begin
                cur_code  = disp_q[i*BCD_W +: BCD_W];
                cur_blank = BLANK_LZ && (i != 0) && zero_above;
            end
        end
    end

    seg7_decode u_decode (
        .code  (cur_code),
        .blank (cur_blank),
        .lit   (cur_lit)
    );

    assign an_onehot = NUM_DIGITS'(1) << idx_q;

    // Next-state logic for the scan position, load buffer and output drive.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        disp_d      = disp_q;
        pend_full_d = pend_full_q;
        if (swap) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
        // accept needs ready, which is low whenever a swap can fire, so the
        // two never collide on the same edge.
        if (accept) begin
            pend_full_d = 1'b1;
        end

        pend_d       = accept ? load_if.digits_in : pend_q;
        ready_d      = !pend_full_d;
        seg_d        = seg_polarity(cur_lit, ACTIVE_LOW);
        an_d         = ACTIVE_LOW ? ~an_onehot : an_onehot;
        frame_done_d = frame_end;
    end

    // Control state and registered outputs; synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample the pre-edge values of the others.
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            pend_full_q  <= 1'b0;
            ready_q      <= 1'b0;
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_full_q  <= pend_full_d;
            ready_q      <= ready_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Pending data word; only meaningful while pend_full_q is set.
    always_ff @(posedge clk) begin
        // NOTE: data guarded by a reset valid flag needs no reset of its own.
        pend_q <= pend_d;
    end

    assign load_if.load_ready = ready_q;
    assign seg                = seg_q;
    assign an                 = an_q;
    assign frame_done         = frame_done_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Self-checking bench for seg_display_scan (4 digits, 4-cycle refresh).
module tb_seg_display_scan;

    localparam int N   = 4;
    localparam int DIV = 4;

    // Lit patterns indexed by BCD code; codes 10..15 are dark.
    localparam logic [6:0] LIT_TAB [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
        7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame_done;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int          m_k      = 0;
    logic [15:0] m_disp   = '0;
    logic [15:0] m_pend   = '0;
    bit          m_pend_v = 1'b0;
    logic [6:0]  e_seg    = 7'h7F;
    logic [3:0]  e_an     = 4'hF;
    bit          e_fd     = 1'b0;
    bit          e_ready  = 1'b0;

    always #5 clk = ~clk;

    seg_display_scan_if #(.NUM_DIGITS(N)) lif ();

    seg_display_scan #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (DIV),
        .ACTIVE_LOW  (1'b1),
        .BLANK_LZ    (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_if    (lif),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        int idx;
        int code;
        bit blank;
        bit accept;
        logic [6:0] lit;
        if (rst) begin
            m_k      = 0;
            m_pend_v = 1'b0;
            m_disp   = '0;
            e_seg    = 7'h7F;
            e_an     = 4'hF;
            e_fd     = 1'b0;
            e_ready  = 1'b0;
        end else begin
            idx    = (m_k / DIV) % N;
            code   = int'((m_disp >> (4 * idx)) & 16'hF);
            blank  = (idx > 0) && ((m_disp >> (4 * idx)) == 16'h0);
            lit    = blank ? 7'b0000000 : LIT_TAB[code];
            e_seg  = ~lit;
            e_an   = ~(4'b0001 << idx);
            e_fd   = (m_k % (DIV * N)) == (DIV * N - 1);
            accept = lif.load_valid && e_ready;
            if (e_fd && m_pend_v) begin
                m_disp   = m_pend;
                m_pend_v = 1'b0;
            end
            if (accept) begin
                m_pend   = lif.digits_in;
                m_pend_v = 1'b1;
            end
            e_ready = !m_pend_v;
            m_k++;
        end
    endtask

    // One clock: update the model at the edge, compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("seg",        32'(seg),            32'(e_seg));
        check("an",         32'(an),             32'(e_an));
        check("frame_done", 32'(frame_done),     32'(e_fd));
        check("load_ready", 32'(lif.load_ready), 32'(e_ready));
    endtask

    task automatic load(input logic [15:0] v);
        lif.digits_in  = v;
        lif.load_valid = 1'b1;
        tick();
        lif.load_valid = 1'b0;
    endtask

    // Run until the model reaches a frame boundary, with a cycle budget.
    task automatic wait_fd(input string tag);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 4 * DIV * N) begin
            tick();
            n++;
            seen = e_fd;
        end
        if (!seen) check({tag, "_fd_timeout"}, 32'(0), 32'(1));
    endtask

    // Check one full frame of fixed pin patterns, digit 0 first.
    task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] exp_s [4];
        logic [3:0] exp_an;
        exp_s = '{s0, s1, s2, s3};
        for (int d = 0; d < N; d++) begin
            exp_an = ~(4'b0001 << d);
            for (int c = 0; c < DIV; c++) begin
                tick();
                check({tag, "_seg"}, 32'(seg), 32'(exp_s[d]));
                check({tag, "_an"},  32'(an),  32'(exp_an));
            end
        end
    endtask

    initial begin
        logic [15:0] rv;
        lif.digits_in  = '0;
        lif.load_valid = 1'b0;
        rst = 1'b1;

        // Reset held for three cycles, then released.
        repeat (3) begin
            tick();
            check("rst_seg",   32'(seg),            32'h7F);
            check("rst_an",    32'(an),             32'hF);
            check("rst_ready", 32'(lif.load_ready), 32'd0);
        end
        rst = 1'b0;
        tick();
        check("ready_after_rst", 32'(lif.load_ready), 32'd1);

        // Single load of 1234, scanned LSD first after the swap.
        load(16'h1234);
        check("s2_ready_drop", 32'(lif.load_ready), 32'd0);
        wait_fd("s2");
        check("s2_ready_back", 32'(lif.load_ready), 32'd1);
        check_frame("s2", 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111);

        // Leading-zero blanking.
        load(16'h0007);
        wait_fd("s3a");
        check_frame("s3a", 7'b0001111, 7'h7F, 7'h7F, 7'h7F);
        load(16'h0000);
        wait_fd("s3b");
        check_frame("s3b", 7'b0000001, 7'h7F, 7'h7F, 7'h7F);

        // Mid-frame load waits for the next frame.
        load(16'h1234);
        wait_fd("s4a");
        repeat (6) tick();
        load(16'h5678);
        wait_fd("s4b");
        check_frame("s4", 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100);

        // Valid held while pending is full is only taken after the swap.
        load(16'h1111);
        check("s5_ready_full", 32'(lif.load_ready), 32'd0);
        lif.digits_in  = 16'h2222;
        lif.load_valid = 1'b1;
        wait_fd("s5a");
        check("s5_ready_at_swap", 32'(lif.load_ready), 32'd1);
        tick();
        lif.load_valid = 1'b0;
        check("s5_accept",   32'(lif.load_ready), 32'd0);
        check("s5_first_d0", 32'(seg),            32'(7'b1001111));
        wait_fd("s5b");
        tick();
        check("s5_second_d0", 32'(seg), 32'(7'b0010010));

        // Reset mid-frame discards the pending value.
        load(16'h9999);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("s6_seg",   32'(seg),            32'h7F);
        check("s6_an",    32'(an),             32'hF);
        check("s6_fd",    32'(frame_done),     32'd0);
        check("s6_ready", 32'(lif.load_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("s6_ready_rel", 32'(lif.load_ready), 32'd1);
        wait_fd("s6");
        check_frame("s6", 7'b0000001, 7'h7F, 7'h7F, 7'h7F);

        // Randomized traffic with zero-heavy digits and occasional resets.
        for (int it = 0; it < 600; it++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int d = 0; d < N; d++) begin
                rv[d*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            lif.digits_in  = rv;
            lif.load_valid = ($urandom_range(0, 3) == 0);
            tick();
        end
        rst = 1'b0;
        lif.load_valid = 1'b0;
        repeat (2 * DIV * N) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
